// File: rtl/half_adder.sv
// Bitwise half adder: combinational sum/carry per lane, a registered copy of both,
// and a saturating count of clock edges at which any lane produced a carry.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic [WIDTH-1:0] outS,
    output logic [WIDTH-1:0] outC,
    output logic [WIDTH-1:0] outS_r,
    output logic [WIDTH-1:0] outC_r,
    output logic [CNT_W-1:0] carry_cnt
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic             w_any_carry;
    logic             w_cnt_sat;

    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic [CNT_W-1:0] r_carry_cnt;

    // Each lane is its own cell; nothing crosses lane boundaries.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign w_sum[i]   = inA[i] ^ inB[i];
        assign w_carry[i] = inA[i] & inB[i];
    end

    assign w_any_carry = |w_carry;
    assign w_cnt_sat   = &r_carry_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= '0;
            r_carry     <= '0;
            r_carry_cnt <= '0;
        end else begin
            r_sum   <= w_sum;
            r_carry <= w_carry;
            // Hold at all-ones rather than wrapping back to zero.
            if (w_any_carry && !w_cnt_sat) begin
                r_carry_cnt <= r_carry_cnt + CNT_W'(1);
            end
        end
    end

    assign outS      = w_sum;
    assign outC      = w_carry;
    assign outS_r    = r_sum;
    assign outC_r    = r_carry;
    assign carry_cnt = r_carry_cnt;

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: three instances cover the 1-lane, 4-lane and
// 2-bit saturating-counter configurations, followed by a randomized 4-lane run.
module tb_half_adder;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst;

    logic       a1, b1, s1, c1, sr1, cr1;
    logic [7:0] cnt1;

    logic [3:0] a4, b4, s4, c4, sr4, cr4;
    logic [7:0] cnt4;

    logic       as, bs, ss, cs, srs, crs;
    logic [1:0] cnts;

    int total = 0;
    int bad = 0;

    logic [3:0] exp_s;
    logic [3:0] exp_c;
    logic [7:0] exp_cnt;

    half_adder #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .inA(a1), .inB(b1),
        .outS(s1), .outC(c1), .outS_r(sr1), .outC_r(cr1), .carry_cnt(cnt1)
    );

    half_adder #(.WIDTH(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .inA(a4), .inB(b4),
        .outS(s4), .outC(c4), .outS_r(sr4), .outC_r(cr4), .carry_cnt(cnt4)
    );

    half_adder #(.WIDTH(1), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .inA(as), .inB(bs),
        .outS(ss), .outC(cs), .outS_r(srs), .outC_r(crs), .carry_cnt(cnts)
    );

    // Clock stays parked low until the combinational phase is over.
    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic comb1(input logic a, input logic b, input logic es, input logic ec);
        a1 = a;
        b1 = b;
        #200;
        chk("comb1_s", {31'd0, s1}, {31'd0, es});
        chk("comb1_c", {31'd0, c1}, {31'd0, ec});
    endtask

    initial begin
        rst = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0;
        as = 1'b0; bs = 1'b0;

        // Truth table with no clock activity.
        comb1(1'b0, 1'b0, 1'b0, 1'b0);
        comb1(1'b0, 1'b1, 1'b1, 1'b0);
        comb1(1'b1, 1'b0, 1'b1, 1'b0);
        comb1(1'b1, 1'b1, 1'b0, 1'b1);

        rst = 1'b1;
        #50;
        chk("comb_during_rst_c", {31'd0, c1}, 32'd1);
        chk("comb_during_rst_s", {31'd0, s1}, 32'd0);
        rst = 1'b0;

        a4 = 4'b1100;
        b4 = 4'b1010;
        #10;
        chk("comb4_s", {28'd0, s4}, 32'h6);
        chk("comb4_c", {28'd0, c4}, 32'h8);

        // Reset for two cycles with A=B=1 held.
        clk_en = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sr1", {31'd0, sr1}, 32'd0);
        chk("rst_cr1", {31'd0, cr1}, 32'd0);
        chk("rst_cnt1", {24'd0, cnt1}, 32'd0);
        chk("rst_cnt4", {24'd0, cnt4}, 32'd0);
        chk("rst_sr4", {28'd0, sr4}, 32'd0);
        rst = 1'b0;

        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk("run_sr1", {31'd0, sr1}, 32'd0);
            chk("run_cr1", {31'd0, cr1}, 32'd1);
            chk("run_cnt1", {24'd0, cnt1}, k);
            chk("run_sr4", {28'd0, sr4}, 32'h6);
            chk("run_cr4", {28'd0, cr4}, 32'h8);
        end

        // Mid-operation reset with carry_cnt at 5.
        rst = 1'b1;
        #1;
        chk("midrst_comb_c_before", {31'd0, c1}, 32'd1);
        @(posedge clk);
        #1;
        chk("midrst_sr1", {31'd0, sr1}, 32'd0);
        chk("midrst_cr1", {31'd0, cr1}, 32'd0);
        chk("midrst_cnt1", {24'd0, cnt1}, 32'd0);
        chk("midrst_comb_c_after", {31'd0, c1}, 32'd1);
        rst = 1'b0;

        // 2-bit counter saturation.
        chk("sat_cnt_start", {30'd0, cnts}, 32'd0);
        as = 1'b1;
        bs = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk("sat_cnt", {30'd0, cnts}, (k < 3) ? k : 3);
        end
        chk("sat_cr", {31'd0, crs}, 32'd1);

        // Random 4-lane run against a reference model.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 100; i++) begin
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            #1;
            exp_s = a4 ^ b4;
            exp_c = a4 & b4;
            chk("rand_s", {28'd0, s4}, {28'd0, exp_s});
            chk("rand_c", {28'd0, c4}, {28'd0, exp_c});
            if (exp_c != 4'd0 && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            @(posedge clk);
            #1;
            chk("rand_sr", {28'd0, sr4}, {28'd0, exp_s});
            chk("rand_cr", {28'd0, cr4}, {28'd0, exp_c});
            chk("rand_cnt", {24'd0, cnt4}, {24'd0, exp_cnt});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Bitwise half adder with a combinational result path plus a registered copy and a saturating carry-event counter.
- Leaf arithmetic cell used by adder and counter datapaths.
- Combinational outputs are valid without any clock activity. Registered outputs serve timing-critical consumers.
- One clock; reset is synchronous and active-high.

Parameters:
- WIDTH, 1, number of independent bit lanes; lane i adds inA[i] and inB[i].
- CNT_W, 8, width of the carry-event counter.

Ports:
- clk  input  1  rising-edge clock for all registered state.
- rst  input  1  synchronous active-high reset.
- inA  input  WIDTH  addend A, one bit per lane.
- inB  input  WIDTH  addend B, one bit per lane.
- outS  output  WIDTH  combinational sum per lane.
- outC  output  WIDTH  combinational carry per lane.
- outS_r  output  WIDTH  outS registered on clk.
- outC_r  output  WIDTH  outC registered on clk.
- carry_cnt  output  CNT_W  number of clock cycles in which any outC bit was 1; saturates.

Behaviour:
- Combinational path:
  - outS[i] = inA[i] XOR inB[i].
  - outC[i] = inA[i] AND inB[i].
  - Zero-latency, purely combinational, no dependence on clk or rst.
  - Must settle correctly with clk held static and rst at any level.
- Truth table per lane (A,B -> S,C): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- outS and outC are never 1 in the same lane simultaneously.
- Registered path:
  - On each rising clk edge with rst=0, outS_r <= outS and outC_r <= outC (1-cycle latency).
  - On a rising edge with rst=1: outS_r, outC_r and carry_cnt <= 0. Reset has priority over all updates.
  - Before the first reset, register contents are don't-care; the bench must not check them.
- Carry counter:
  - On a rising edge with rst=0, carry_cnt increments by 1 if any bit of outC is 1 at that edge.
  - It holds at all-ones (2^CNT_W - 1) and never wraps to 0.
- Reset mid-operation:
  - Affects only registered outputs and carry_cnt.
  - outS and outC keep tracking inputs during reset.
- Lanes are fully independent; no carry propagates between lanes.
- No X propagation from an unused lane into other lanes.

Test Plan:
- WIDTH=1, no clock: apply (A,B) = 00, 01, 10, 11, each held 200 ns -> (outS,outC) = (0,0), (1,0), (1,0), (0,1).
- Clocked, rst=1 for 2 cycles then 0; A=1, B=1 held -> outS_r=0, outC_r=1 one cycle after reset release; carry_cnt increments 1,2,3 on successive edges.
- Assert rst while A=B=1 with carry_cnt=5 -> next edge gives outS_r=0, outC_r=0, carry_cnt=0; outC stays 1 combinationally throughout.
- CNT_W=2, A=B=1 for 6 cycles -> carry_cnt counts 1,2,3,3,3,3 (saturates, no wrap).
- WIDTH=4, inA=4'b1100, inB=4'b1010 -> outS=4'b0110, outC=4'b1000; registered copies match one cycle later.
- Random A/B over 100 cycles -> outS_r/outC_r equal the previous cycle's XOR/AND.
- Random A/B over 100 cycles -> carry_cnt equals the count of cycles with outC≠0, capped at saturation.
